// File: rtl/fpaddsub_norm_shift.sv
// Post-subtraction normalization: left-shifts the significand by the leading-zero
// count (clamped by the exponent) and adjusts the exponent; 2-stage valid/ready pipe.
module fpaddsub_norm_shift #(
   parameter int unsigned SWR = 55,
   parameter int unsigned EW  = 11,
   parameter int unsigned LZW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           Valid_i,
   output logic           Ready_o,
   input  logic [SWR-1:0] Sgf_i,
   input  logic [EW-1:0]  Exp_i,
   input  logic [LZW-1:0] LZC_i,
   output logic           Valid_o,
   input  logic           Ready_i,
   output logic [SWR-1:0] Sgf_o,
   output logic [EW-1:0]  Exp_o,
   output logic           Zero_o,
   output logic           Underflow_o
);

   localparam int unsigned FINE_W = 3;

   logic           w_adv1;
   logic           w_adv2;
   logic           w_zero;
   logic           w_lt;
   logic           w_uf;
   logic [LZW-1:0] w_sh;
   logic [EW-1:0]  w_exp;
   logic [SWR-1:0] w_coarse;

   logic              r1_v;
   logic [SWR-1:0]    r1_sgf;
   logic [EW-1:0]     r1_exp;
   logic [FINE_W-1:0] r1_fine;
   logic              r1_zero;
   logic              r1_uf;

   logic           r2_v;
   logic [SWR-1:0] r2_sgf;
   logic [EW-1:0]  r2_exp;
   logic           r2_zero;
   logic           r2_uf;

   // Stall control: a stage advances when it is empty or its successor advances.
   assign w_adv2  = !r2_v || Ready_i;
   assign w_adv1  = !r1_v || w_adv2;
   assign Ready_o = w_adv1;

   // Shift amount is the LZC clamped to the exponent so the exponent never goes negative.
   always_comb begin
      w_zero   = (LZC_i >= LZW'(SWR));
      w_lt     = (EW'(LZC_i) < Exp_i);
      w_uf     = !w_zero && !w_lt;
      w_sh     = '0;
      w_exp    = '0;
      w_coarse = '0;
      if (!w_zero) begin
         w_sh     = w_lt ? LZC_i : LZW'(Exp_i);
         w_exp    = Exp_i - EW'(w_sh);
         w_coarse = Sgf_i << {w_sh[LZW-1:FINE_W], FINE_W'(0)};
      end
   end

   // Stage 1: coarse (byte) shift, exponent adjust and flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r1_v    <= 1'b0;
         r1_sgf  <= '0;
         r1_exp  <= '0;
         r1_fine <= '0;
         r1_zero <= 1'b0;
         r1_uf   <= 1'b0;
      end else if (w_adv1) begin
         r1_v    <= Valid_i;
         r1_sgf  <= w_coarse;
         r1_exp  <= w_exp;
         r1_fine <= w_sh[FINE_W-1:0];
         r1_zero <= w_zero;
         r1_uf   <= w_uf;
      end
   end

   // Stage 2: fine (bit) shift and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r2_v    <= 1'b0;
         r2_sgf  <= '0;
         r2_exp  <= '0;
         r2_zero <= 1'b0;
         r2_uf   <= 1'b0;
      end else if (w_adv2) begin
         r2_v    <= r1_v;
         r2_sgf  <= r1_sgf << r1_fine;
         r2_exp  <= r1_exp;
         r2_zero <= r1_zero;
         r2_uf   <= r1_uf;
      end
   end

   assign Valid_o     = r2_v;
   assign Sgf_o       = r2_sgf;
   assign Exp_o       = r2_exp;
   assign Zero_o      = r2_zero;
   assign Underflow_o = r2_uf;

endmodule

// File: tb/tb_fpaddsub_norm_shift.sv
// Scoreboard bench for fpaddsub_norm_shift: directed vectors, LZC sweep,
// backpressure, random ready toggling and mid-flight reset.
module tb_fpaddsub_norm_shift;

   typedef struct packed {
      logic [54:0] sgf;
      logic [10:0] ex;
      logic        z;
      logic        uf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        Valid_i;
   logic        Ready_o;
   logic [54:0] Sgf_i;
   logic [10:0] Exp_i;
   logic [5:0]  LZC_i;
   logic        Valid_o;
   logic        Ready_i;
   logic [54:0] Sgf_o;
   logic [10:0] Exp_o;
   logic        Zero_o;
   logic        Underflow_o;

   logic fix_rdy  = 1'b1;
   logic rand_rdy = 1'b1;
   logic rand_en  = 1'b0;
   assign Ready_i = rand_en ? rand_rdy : fix_rdy;

   int   total = 0;
   int   bad   = 0;
   res_t sbq[$];
   res_t held;
   logic prev_stall = 1'b0;

   fpaddsub_norm_shift dut (
      .clk(clk), .rst(rst), .Valid_i(Valid_i), .Ready_o(Ready_o),
      .Sgf_i(Sgf_i), .Exp_i(Exp_i), .LZC_i(LZC_i), .Valid_o(Valid_o),
      .Ready_i(Ready_i), .Sgf_o(Sgf_o), .Exp_o(Exp_o), .Zero_o(Zero_o),
      .Underflow_o(Underflow_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1 rand_rdy = 1'($urandom_range(0, 1));
   end

   function automatic res_t model(logic [54:0] s, logic [10:0] e, logic [5:0] l);
      res_t r;
      int   sh;
      if (int'(l) >= 55) begin
         r = '{sgf: '0, ex: '0, z: 1'b1, uf: 1'b0};
      end else begin
         sh   = (int'(l) < int'(e)) ? int'(l) : int'(e);
         r.sgf = s << sh;
         r.ex  = 11'(int'(e) - sh);
         r.z   = 1'b0;
         r.uf  = (int'(l) >= int'(e));
      end
      return r;
   endfunction

   // Output monitor: pops on each output transfer, checks hold while stalled.
   always @(negedge clk) begin
      res_t e;
      if (rst) begin
         if (Valid_o && prev_stall) begin
            total++;
            assert ({Sgf_o, Exp_o, Zero_o, Underflow_o} === held) else begin
               bad++;
               $error("FAIL stall_hold got=%h want=%h", {Sgf_o, Exp_o, Zero_o, Underflow_o}, held);
            end
         end
         held       = {Sgf_o, Exp_o, Zero_o, Underflow_o};
         prev_stall = Valid_o && !Ready_i;
         if (Valid_o && Ready_i) begin
            total++;
            if (sbq.size() == 0) begin
               bad++;
               $error("FAIL unexpected_out got=%h want=none", held);
            end else begin
               e = sbq.pop_front();
               assert ({Sgf_o, Exp_o, Zero_o, Underflow_o} === e) else begin
                  bad++;
                  $error("FAIL out sgf=%h exp=%0d z=%b uf=%b want sgf=%h exp=%0d z=%b uf=%b",
                         Sgf_o, Exp_o, Zero_o, Underflow_o, e.sgf, e.ex, e.z, e.uf);
               end
            end
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Drives one op (called at posedge+1) and returns right after it is accepted.
   task automatic send_exp(input logic [54:0] s, input logic [10:0] e, input logic [5:0] l,
                           input res_t want);
      bit done = 0;
      Sgf_i = s; Exp_i = e; LZC_i = l; Valid_i = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (Ready_o) begin
            sbq.push_back(want);
            done = 1;
         end
         @(posedge clk); #1;
      end
      Valid_i = 1'b0;
      if (!done) begin
         total++; bad++;
         $error("FAIL accept_timeout got=no_accept want=accept");
      end
   endtask

   task automatic send(input logic [54:0] s, input logic [10:0] e, input logic [5:0] l);
      send_exp(s, e, l, model(s, e, l));
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 500) begin
         @(posedge clk); #1; n++;
      end
      total++;
      assert (sbq.size() == 0) else begin
         bad++;
         $error("FAIL drain left=%0d want=0", sbq.size());
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   initial begin
      logic [54:0] s;
      logic [54:0] one;
      logic [5:0]  l;
      logic [10:0] e;
      int          acc;
      one     = 55'd1;
      rst     = 1'b0;
      Valid_i = 1'b0;
      Sgf_i   = '0; Exp_i = '0; LZC_i = '0;
      #12;
      chk("rst_valid", 64'(Valid_o), 64'd0);
      chk("rst_ready", 64'(Ready_o), 64'd1);
      chk("rst_data", 64'({Sgf_o, Exp_o, Zero_o, Underflow_o} != 0), 64'd0);
      @(posedge clk); #1 rst = 1'b1;

      // Normal shift with latency check.
      send_exp(55'h04_0000_0000_0000, 11'd100, 6'd4,
               '{sgf: 55'h40_0000_0000_0000, ex: 11'd96, z: 1'b0, uf: 1'b0});
      chk("lat_n1", 64'(Valid_o), 64'd0);
      @(posedge clk); #1;
      chk("lat_n2", 64'(Valid_o), 64'd1);
      drain();

      send_exp(55'd0, 11'd700, 6'd55, '{sgf: '0, ex: '0, z: 1'b1, uf: 1'b0});
      send_exp(55'h12_3456_789A_BCDE, 11'd9, 6'd63, '{sgf: '0, ex: '0, z: 1'b1, uf: 1'b0});
      send_exp(one << 44, 11'd3, 6'd10, '{sgf: one << 47, ex: 11'd0, z: 1'b0, uf: 1'b1});
      send_exp(55'h40_0000_0000_0001, 11'd1, 6'd0,
               '{sgf: 55'h40_0000_0000_0001, ex: 11'd1, z: 1'b0, uf: 1'b0});
      send_exp(one << 30, 11'd0, 6'd24, '{sgf: one << 30, ex: 11'd0, z: 1'b0, uf: 1'b1});
      send_exp(one << 49, 11'd5, 6'd5, '{sgf: one << 54, ex: 11'd0, z: 1'b0, uf: 1'b1});
      send_exp(one << 49, 11'd6, 6'd5, '{sgf: one << 54, ex: 11'd1, z: 1'b0, uf: 1'b0});
      send_exp(one, 11'd2047, 6'd54, '{sgf: one << 54, ex: 11'd1993, z: 1'b0, uf: 1'b0});
      drain();

      // LZC sweep covering every coarse/fine shift combination.
      for (int k = 0; k < 55; k++) begin
         send_exp(one << (54 - k), 11'd1000, 6'(k),
                  '{sgf: one << 54, ex: 11'(1000 - k), z: 1'b0, uf: 1'b0});
      end
      drain();

      // Backpressure: two accepts then Ready_o drops.
      fix_rdy = 1'b0;
      send(55'h7F_FFFF_FFFF_FFFF, 11'd50, 6'd0);
      send(55'h01_2345_6789_ABCD, 11'd40, 6'd6);
      Sgf_i = 55'h00_0000_0000_FFFF; Exp_i = 11'd70; LZC_i = 6'd39; Valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(Ready_o), 64'd0);
         @(posedge clk); #1;
      end
      chk("bp_queued", 64'(sbq.size()), 64'd2);
      fix_rdy = 1'b1;
      send(55'h00_0000_0000_FFFF, 11'd70, 6'd39);
      send(55'h00_0000_0000_0003, 11'd20, 6'd53);
      send(55'h00_0100_0000_0000, 11'd800, 6'd14);
      drain();

      // Random ready toggling with consistent random operands.
      rand_en = 1'b1;
      for (int i = 0; i < 40; i++) begin
         l = 6'($urandom_range(0, 56));
         e = (i % 3 == 0) ? 11'($urandom_range(0, 60)) : 11'($urandom_range(0, 2047));
         s = (int'(l) >= 55) ? 55'd0
             : (((one << (54 - int'(l))) | (55'({$urandom, $urandom}) & ((one << (54 - int'(l))) - one))));
         send(s, e, l);
      end
      drain();
      rand_en = 1'b0;

      // Mid-flight reset with both stages full.
      fix_rdy = 1'b0;
      send(one << 20, 11'd500, 6'd34);
      send(one << 10, 11'd500, 6'd44);
      @(negedge clk);
      chk("mid_full_ready", 64'(Ready_o), 64'd0);
      chk("mid_full_valid", 64'(Valid_o), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(Valid_o), 64'd0);
      chk("mid_rst_ready", 64'(Ready_o), 64'd1);
      chk("mid_rst_data", 64'({Sgf_o, Exp_o, Zero_o, Underflow_o} != 0), 64'd0);
      sbq.delete();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      fix_rdy = 1'b1;
      send_exp(one << 3, 11'd60, 6'd51, '{sgf: one << 54, ex: 11'd9, z: 1'b0, uf: 1'b0});
      chk("post_rst_n1", 64'(Valid_o), 64'd0);
      @(posedge clk); #1;
      chk("post_rst_n2", 64'(Valid_o), 64'd1);
      drain();
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fpaddsub_norm_shift.md
# fpaddsub_norm_shift

Post-subtraction normalization stage of the FP add/sub datapath (arch2). It sits directly downstream of the 55-bit leading-one priority encoder and consumes that encoder's 6-bit leading-zero count. It left-shifts the unnormalized significand so that bit [SWR-1] is 1, and adjusts the biased exponent to match, with zero and underflow clamping. It is a 2-stage valid/ready pipeline that accepts one operation per cycle.

## Interface
- SWR, 55: significand width (working width including guard/round/sticky bits).
- EW, 11: biased exponent width.
- LZW, 6: leading-zero count width, equal to ceil(log2(SWR+1)).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- Valid_i  in  1  input operation valid.
- Ready_o  out  1  stage can accept on this cycle.
- Sgf_i  in  SWR  unnormalized significand.
- Exp_i  in  EW  biased exponent associated with Sgf_i.
- LZC_i  in  LZW  leading-zero count from the priority encoder. 0 means bit [SWR-1] is set. Any value of SWR or more means Sgf_i is zero.
- Valid_o  out  1  output valid.
- Ready_i  in  1  downstream accepts.
- Sgf_o  out  SWR  normalized significand.
- Exp_o  out  EW  adjusted exponent.
- Zero_o  out  1  result significand is zero.
- Underflow_o  out  1  the shift was clamped by the exponent.

## Operation
- Transfer rules: an input transfer occurs when Valid_i and Ready_o are both 1. An output transfer occurs when Valid_o and Ready_i are both 1.
- Zero: if LZC_i ≥ SWR, then Zero_o=1, Sgf_o=0, Exp_o=0 and Underflow_o=0.
- Shift amount, non-zero case: SH = LZC_i if LZC_i < Exp_i; otherwise SH = Exp_i.
- Results, non-zero case:
  - Sgf_o = Sgf_i << SH, with zero fill at the LSB.
  - Exp_o = Exp_i − SH. This is never negative.
  - Underflow_o = (LZC_i ≥ Exp_i).
  - Bits shifted out are discarded. They are zero by the definition of LZC_i when LZC_i is accurate.
- Exp_i = 0 with a non-zero significand: SH=0, the significand passes through unchanged, Underflow_o=1.
- Stage 1 (S1) registers:
  - SH, zero flag, underflow flag, and Exp_i − SH;
  - the coarse shift, Sgf_i << (SH[5:3]·8).
- Stage 2 (S2) applies the fine shift (SH[2:0]) and registers all outputs.
- Inconsistent LZC_i (not the true count) is not detected. The output is the literal shift result.

## Timing
- Stall control, with V1 and V2 as the internal stage valid bits:
  - adv2 = !V2 | Ready_i.
  - adv1 = !V1 | adv2.
  - Ready_o = adv1. This is a combinational path from Ready_i and is permitted.
- S1 loads when adv1. V1 takes the value of Valid_i on that edge.
- S2 loads from S1 when adv2. V2 takes the value of V1 on that edge.
- Valid_o = V2.
- A stage that does not advance holds all of its registers. Sgf_o, Exp_o, Zero_o and Underflow_o are stable while Valid_o=1 and Ready_i=0.
- Latency: an input accepted at edge n appears on the outputs after edge n+1, i.e. Valid_o=1 in cycle n+2.
- Throughput: 1 per cycle with Ready_i held at 1.
- Buffering: at most 2 operations in flight. With Ready_i=0, Ready_o drops once V1 and V2 are both 1.
- Simultaneous accept and emit on the same edge is allowed. Order is strictly FIFO and no operation is dropped or duplicated.
- Reset: while rst=0, asynchronously clear V1, V2 and all data registers.
  - Output values in reset: Valid_o=0, Sgf_o=0, Exp_o=0, Zero_o=0, Underflow_o=0, Ready_o=1.
  - Reset asserted mid-operation discards in-flight data.
  - Reset deassertion is synchronous to clk at the integration level. The first transfer is possible on the first edge after release.
- Data registers may be written while their stage valid is 0. Output data is only meaningful while Valid_o=1.

## Test plan
- Normal shift: Sgf_i = 55'h04_0000_0000_0000 (bit 50), LZC_i=4, Exp_i=100, Ready_i=1 → 2 cycles later Sgf_o = 55'h40_0000_0000_0000, Exp_o=96, Zero_o=0, Underflow_o=0.
- Zero operand: Sgf_i=0, LZC_i=55, Exp_i=700 → Sgf_o=0, Exp_o=0, Zero_o=1, Underflow_o=0.
- Underflow clamp: Sgf_i = bit 44 only, LZC_i=10, Exp_i=3 → Sgf_o = bit 47 only, Exp_o=0, Underflow_o=1.
- No shift, and all fine-shift values:
  - LZC_i=0, Exp_i=1 → passthrough, Exp_o=1, Underflow_o=0.
  - Sweep LZC_i from 0 to 54 with a single set bit at position 54−LZC_i and Exp_i=1000 → Sgf_o = bit 54 only and Exp_o = 1000−LZC_i for every LZC_i.
- Backpressure:
  - Stream 5 back-to-back ops with Ready_i=0 → Ready_o falls after 2 accepts.
  - Release Ready_i → all 5 ops emerge in order, with outputs stable while stalled.
  - Toggle Ready_i randomly → no loss or duplication.
- Reset mid-flight: pull rst low with V1=V2=1 → Valid_o=0 and all outputs 0 immediately, without waiting for clk. After release, a new op completes with 2-cycle latency.
